// File: rtl/word_framer.sv
// word_framer: bit-to-word framer and divided word-clock generator for the
// serial receive path. Shifts in one bit per bitclk edge and emits a WIDTH-bit
// word with a one-cycle valid strobe. Alignment is either moved by manual
// bitslip pulses or found automatically from 8b10b commas, with lock tracking.
module word_framer #(
    parameter int               WIDTH        = 10,
    parameter bit               AUTO_ALIGN   = 1'b1,
    parameter logic [WIDTH-1:0] COMMA_P      = WIDTH'(10'b0011111010),
    parameter logic [WIDTH-1:0] COMMA_N      = WIDTH'(10'b1100000101),
    parameter int               MISALIGN_MAX = 4
) (
    input  logic             bitclk_in,
    input  logic             rstn_in,
    input  logic             sdata_in,
    input  logic             bitslip_in,
    output logic             bitclk_out,
    output logic             byteclk_out,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid_out,
    output logic             comma_out,
    output logic             locked_out
);

    localparam int             PH_W      = $clog2(WIDTH);
    localparam logic [PH_W-1:0] PH_LAST  = PH_W'(WIDTH - 1);
    localparam logic [PH_W-1:0] PH_HALF  = PH_W'(WIDTH / 2);
    localparam logic [PH_W-1:0] PH_ONE   = PH_W'(1);
    localparam logic [4:0]      ERR_LIMIT = 5'(MISALIGN_MAX);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-2:0] shreg;
    logic [PH_W-1:0]  ph;
    logic [3:0]       err;

    logic [WIDTH-1:0] win;
    logic             comma_hit;
    logic             slip;
    logic             emit;
    logic [PH_W-1:0]  ph_next;
    logic [4:0]       err_inc;

    assign bitclk_out = bitclk_in;

    // Decide whether this edge closes a word and where the phase counter goes next.
    always_comb begin
        win       = {shreg, sdata_in};
        comma_hit = (win == COMMA_P) || (win == COMMA_N);
        slip      = (AUTO_ALIGN == 1'b0) && bitslip_in;
        err_inc   = {1'b0, err} + 5'd1;
        emit      = 1'b0;
        if (slip) begin
            emit = 1'b0;
        end else if (ph == PH_LAST) begin
            emit = 1'b1;
        end else if (AUTO_ALIGN && (state == HUNT) && comma_hit) begin
            emit = 1'b1;
        end
        if (emit) begin
            ph_next = '0;
        end else if (slip) begin
            ph_next = ph;
        end else begin
            ph_next = ph + PH_ONE;
        end
    end

    // Shift register, phase counter, registered outputs and the alignment FSM.
    always_ff @(posedge bitclk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            shreg          <= '0;
            ph             <= '0;
            err            <= '0;
            word_out       <= '0;
            word_valid_out <= 1'b0;
            comma_out      <= 1'b0;
            byteclk_out    <= 1'b0;
            locked_out     <= 1'b0;
            state          <= HUNT;
        end else begin
            shreg          <= win[WIDTH-2:0];
            ph             <= ph_next;
            byteclk_out    <= (ph_next < PH_HALF);
            word_valid_out <= emit;
            if (emit) begin
                word_out  <= win;
                comma_out <= comma_hit;
            end
            if (AUTO_ALIGN) begin
                case (state)
                    HUNT: begin
                        if (comma_hit) begin
                            state      <= LOCKED;
                            locked_out <= 1'b1;
                            err        <= '0;
                        end
                    end
                    LOCKED: begin
                        if (comma_hit) begin
                            if (ph == PH_LAST) begin
                                err <= '0;
                            end else if (err_inc == ERR_LIMIT) begin
                                state      <= HUNT;
                                locked_out <= 1'b0;
                                err        <= '0;
                            end else begin
                                err <= err_inc[3:0];
                            end
                        end
                    end
                    default: begin
                        state      <= HUNT;
                        locked_out <= 1'b0;
                        err        <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_word_framer.sv
// tb_word_framer: drives three framer instances (10-bit manual, 9-bit manual,
// 10-bit comma-aligned) and checks every edge against a scoreboard of expected
// word strobes built from the bits the bench itself sends.
module tb_word_framer;

    localparam logic [9:0] P10 = 10'b0011111010;
    localparam logic [9:0] N10 = 10'b1100000101;
    localparam logic [8:0] P9  = 9'b011111010;
    localparam logic [8:0] N9  = 9'b100000101;

    typedef struct {
        int          edge_no;
        logic [15:0] word;
        logic        comma;
        logic        locked;
    } exp_t;

    typedef struct {
        logic sdata;
        logic exp_bc_m;
        logic exp_bc_9;
        logic exp_v_m;
        logic exp_v_9;
    } vec_t;

    logic bitclk = 1'b0;
    logic clk_run = 1'b0;
    logic rstn = 1'b0;
    logic sd_m = 1'b0, sl_m = 1'b0, sd_a = 1'b0, sl_a = 1'b0;

    logic       bco_m, bc_m, v_m, c_m, l_m;
    logic [9:0] w_m;
    logic       bco_9, bc_9, v_9, c_9, l_9;
    logic [8:0] w_9;
    logic       bco_a, bc_a, v_a, c_a, l_a;
    logic [9:0] w_a;

    int n_checks = 0;
    int n_err = 0;
    int edge_cnt, cnt_m, cnt_9, pat_idx, next_emit_a;
    int first_emit_m, last_emit_m, first_emit_9, last_emit_9;
    logic [15:0] hist_m, hist_a;
    logic exp_locked_a, chk_m, chk_a, sl_a_hold;
    logic [9:0] pat_m = 10'b1011001110;
    logic [9:0] comma_p_v = P10;
    exp_t q_m[$], q_9[$], q_a[$];
    vec_t vecs[20];

    word_framer #(.WIDTH(10), .AUTO_ALIGN(1'b0), .COMMA_P(P10), .COMMA_N(N10), .MISALIGN_MAX(4)) dut_m (
        .bitclk_in(bitclk), .rstn_in(rstn), .sdata_in(sd_m), .bitslip_in(sl_m),
        .bitclk_out(bco_m), .byteclk_out(bc_m), .word_out(w_m), .word_valid_out(v_m),
        .comma_out(c_m), .locked_out(l_m));

    word_framer #(.WIDTH(9), .AUTO_ALIGN(1'b0), .COMMA_P(P9), .COMMA_N(N9), .MISALIGN_MAX(4)) dut_9 (
        .bitclk_in(bitclk), .rstn_in(rstn), .sdata_in(sd_m), .bitslip_in(sl_m),
        .bitclk_out(bco_9), .byteclk_out(bc_9), .word_out(w_9), .word_valid_out(v_9),
        .comma_out(c_9), .locked_out(l_9));

    word_framer #(.WIDTH(10), .AUTO_ALIGN(1'b1), .COMMA_P(P10), .COMMA_N(N10), .MISALIGN_MAX(4)) dut_a (
        .bitclk_in(bitclk), .rstn_in(rstn), .sdata_in(sd_a), .bitslip_in(sl_a),
        .bitclk_out(bco_a), .byteclk_out(bc_a), .word_out(w_a), .word_valid_out(v_a),
        .comma_out(c_a), .locked_out(l_a));

    // Bit clock, gated so it can be parked low for the reset-without-clock checks.
    always #5 if (clk_run) bitclk = ~bitclk;

    // Hard time limit so the run always reaches an end.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("[TB] FAIL %s actual=%0h required=%0h edge=%0d", name, act, req, edge_cnt);
        end
    endtask

    task automatic monitorOne(input string tag, input bit due, input exp_t e, input logic v,
                              input logic [15:0] w, input logic c, input logic l, input logic idle_l);
        if (due) begin
            checkOutput({tag, "_valid"}, 16'(v), 16'd1);
            checkOutput({tag, "_word"}, w, e.word);
            checkOutput({tag, "_comma"}, 16'(c), 16'(e.comma));
            checkOutput({tag, "_locked"}, 16'(l), 16'(e.locked));
        end else begin
            checkOutput({tag, "_idle_valid"}, 16'(v), 16'd0);
            checkOutput({tag, "_idle_locked"}, 16'(l), 16'(idle_l));
        end
    endtask

    task automatic clearState();
        edge_cnt = 0; cnt_m = 0; cnt_9 = 0; pat_idx = 0;
        hist_m = '0; hist_a = '0;
        q_m.delete(); q_9.delete(); q_a.delete();
        first_emit_m = -1; last_emit_m = -1; first_emit_9 = -1; last_emit_9 = -1;
        next_emit_a = 10; exp_locked_a = 1'b0; sl_a_hold = 1'b0;
    endtask

    task automatic checkResetAll();
        checkOutput("rst_m_word", 16'(w_m), 16'd0);
        checkOutput("rst_m_flags", 16'({v_m, c_m, bc_m, l_m}), 16'd0);
        checkOutput("rst_9_word", 16'(w_9), 16'd0);
        checkOutput("rst_9_flags", 16'({v_9, c_9, bc_9, l_9}), 16'd0);
        checkOutput("rst_a_word", 16'(w_a), 16'd0);
        checkOutput("rst_a_flags", 16'({v_a, c_a, bc_a, l_a}), 16'd0);
        checkOutput("rst_bitclk_out", 16'({bco_m, bco_9, bco_a}), 16'd0);
    endtask

    // One bit-clock edge: drive inputs, record expected strobes, then compare.
    task automatic applyStimulus(input logic dm, input logic sm, input logic da, input logic sa);
        exp_t e;
        bit   due;
        sd_m = dm; sl_m = sm; sd_a = da; sl_a = sa;
        @(posedge bitclk);
        edge_cnt++;
        hist_m = {hist_m[14:0], dm};
        hist_a = {hist_a[14:0], da};
        if (chk_m && !sm) begin
            cnt_m++;
            cnt_9++;
            if (cnt_m == 10) begin
                e.edge_no = edge_cnt; e.word = 16'(hist_m[9:0]);
                e.comma = (hist_m[9:0] == P10) || (hist_m[9:0] == N10); e.locked = 1'b0;
                q_m.push_back(e);
                cnt_m = 0;
            end
            if (cnt_9 == 9) begin
                e.edge_no = edge_cnt; e.word = 16'(hist_m[8:0]);
                e.comma = (hist_m[8:0] == P9) || (hist_m[8:0] == N9); e.locked = 1'b0;
                q_9.push_back(e);
                cnt_9 = 0;
            end
        end
        if (chk_a && edge_cnt == next_emit_a) begin
            e.edge_no = edge_cnt; e.word = 16'(hist_a[9:0]);
            e.comma = (hist_a[9:0] == P10) || (hist_a[9:0] == N10); e.locked = exp_locked_a;
            q_a.push_back(e);
            next_emit_a += 10;
        end
        #1;
        if (chk_m) begin
            checkOutput("m_bitclk_out", 16'({bco_m, bco_9}), 16'd3);
            if (v_m) begin last_emit_m = edge_cnt; if (first_emit_m < 0) first_emit_m = edge_cnt; end
            if (v_9) begin last_emit_9 = edge_cnt; if (first_emit_9 < 0) first_emit_9 = edge_cnt; end
            due = (q_m.size() > 0) && (q_m[0].edge_no == edge_cnt);
            e = due ? q_m.pop_front() : e;
            monitorOne("m", due, e, v_m, 16'(w_m), c_m, l_m, 1'b0);
            due = (q_9.size() > 0) && (q_9[0].edge_no == edge_cnt);
            e = due ? q_9.pop_front() : e;
            monitorOne("w9", due, e, v_9, 16'(w_9), c_9, l_9, 1'b0);
        end
        if (chk_a) begin
            due = (q_a.size() > 0) && (q_a[0].edge_no == edge_cnt);
            e = due ? q_a.pop_front() : e;
            monitorOne("a", due, e, v_a, 16'(w_a), c_a, l_a, exp_locked_a);
        end
    endtask

    task automatic stepM(input logic slip);
        logic b;
        b = pat_m[9 - pat_idx];
        applyStimulus(b, slip, 1'b0, 1'b0);
        pat_idx = (pat_idx + 1) % 10;
    endtask

    task automatic sendA(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) applyStimulus(1'b0, 1'b0, bits[i], sl_a_hold);
    endtask

    // Comma landing three bits into a word, i.e. on the wrong phase.
    task automatic wrongBlockA(input bit drop);
        sendA(16'b101, 3);
        sendA(16'(comma_p_v[9:1]), 9);
        if (drop) exp_locked_a = 1'b0;
        sendA(16'(comma_p_v[0]), 1);
        sendA(16'b0101010, 7);
    endtask

    task automatic parkAndReset(input bit check);
        if (clk_run) @(negedge bitclk);
        clk_run = 1'b0;
        #2 rstn = 1'b0;
        #1;
        if (check) checkResetAll();
        #4 rstn = 1'b1;
        clearState();
        clk_run = 1'b1;
    endtask

    initial begin
        logic [19:0] sd_bits, bcm_bits, bc9_bits, vm_bits, v9_bits;
        sd_bits  = 20'b10110011101011001110;
        bcm_bits = 20'b11110000011111000001;
        bc9_bits = 20'b11100000111100000111;
        vm_bits  = 20'b00000000010000000001;
        v9_bits  = 20'b00000000100000000100;
        for (int i = 0; i < 20; i++) begin
            vecs[i].sdata    = sd_bits[19 - i];
            vecs[i].exp_bc_m = bcm_bits[19 - i];
            vecs[i].exp_bc_9 = bc9_bits[19 - i];
            vecs[i].exp_v_m  = vm_bits[19 - i];
            vecs[i].exp_v_9  = v9_bits[19 - i];
        end
        chk_m = 1'b0; chk_a = 1'b0;
        clearState();

        // Reset state with no clock running.
        #3 checkResetAll();
        #2 rstn = 1'b1;
        clearState();
        chk_m = 1'b1;
        clk_run = 1'b1;

        // Free-running manual framing: word timing and word-clock duty.
        for (int i = 0; i < 20; i++) begin
            applyStimulus(vecs[i].sdata, 1'b0, 1'b0, 1'b0);
            checkOutput("tbl_bc_m", 16'(bc_m), 16'(vecs[i].exp_bc_m));
            checkOutput("tbl_bc_9", 16'(bc_9), 16'(vecs[i].exp_bc_9));
            checkOutput("tbl_v_m", 16'(v_m), 16'(vecs[i].exp_v_m));
            checkOutput("tbl_v_9", 16'(v_9), 16'(vecs[i].exp_v_9));
        end
        checkOutput("m_first_word", 16'(w_m), 16'h2CE);

        // One slip pulse, then a two-cycle slip.
        pat_idx = 0;
        for (int e = 21; e <= 45; e++) stepM((e == 25) || (e == 35) || (e == 36));
        checkOutput("m_slip_last_emit", 16'(last_emit_m), 16'd43);
        checkOutput("w9_slip_last_emit", 16'(last_emit_9), 16'd39);

        // Mid-word reset with the clock parked low.
        parkAndReset(1'b1);
        for (int e = 1; e <= 20; e++) stepM(1'b0);
        checkOutput("m_rst_first_emit", 16'(first_emit_m), 16'd10);
        checkOutput("w9_rst_first_emit", 16'(first_emit_9), 16'd9);
        checkOutput("m_rst_word", 16'(w_m), 16'h2CE);

        // Comma alignment: hunt, lock, tolerate misaligned commas, then unlock.
        chk_m = 1'b0;
        parkAndReset(1'b0);
        chk_a = 1'b1;
        sendA(16'b000, 3);
        sendA(16'(comma_p_v[9:3]), 7);
        next_emit_a = edge_cnt + 3;
        sendA(16'(comma_p_v[2:1]), 2);
        exp_locked_a = 1'b1;
        sendA(16'(comma_p_v[0]), 1);
        checkOutput("a_lock_comma", 16'({c_a, l_a}), 16'd3);
        sendA(16'b1001110100, 10);
        checkOutput("a_after_lock_word", 16'(w_a), 16'h274);
        sl_a_hold = 1'b1;
        wrongBlockA(1'b0);
        sl_a_hold = 1'b0;
        wrongBlockA(1'b0);
        wrongBlockA(1'b0);
        sendA(16'(comma_p_v), 10);
        checkOutput("a_aligned_comma", 16'({v_a, c_a, l_a}), 16'd7);
        wrongBlockA(1'b0);
        wrongBlockA(1'b0);
        wrongBlockA(1'b0);
        checkOutput("a_still_locked", 16'(l_a), 16'd1);
        wrongBlockA(1'b1);
        checkOutput("a_unlocked", 16'(l_a), 16'd0);
        sendA(16'b10101, 5);
        sendA(16'(comma_p_v[9:1]), 9);
        next_emit_a = edge_cnt + 1;
        exp_locked_a = 1'b1;
        sendA(16'(comma_p_v[0]), 1);
        checkOutput("a_relock", 16'({v_a, c_a, l_a}), 16'd7);
        sendA(16'b1010101010, 10);
        checkOutput("a_relock_next_emit", 16'(v_a), 16'd1);

        checkOutput("q_m_empty", 16'(q_m.size()), 16'd0);
        checkOutput("q_9_empty", 16'(q_9.size()), 16'd0);
        checkOutput("q_a_empty", 16'(q_a.size()), 16'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
